// File: rtl/multi_edge_detector_if.sv
// Bundle of the edge detector's functional signals.
//   master : drives in/mode/clr/cnt_clr, observes the detector outputs
//   slave  : the detector itself
//   in        raw level inputs, may be asynchronous to the clock
//   mode      event qualifier: 00 none, 01 rising, 10 falling, 11 both
//   clr       per-channel write-1-to-clear for sticky
//   cnt_clr   synchronous clear of evt_count
//   level     filtered level per channel
//   pedge     one-cycle pulse on accepted 0->1 of level
//   nedge     one-cycle pulse on accepted 1->0 of level
//   evt       pedge/nedge qualified by mode
//   sticky    latched evt per channel
//   irq       OR of sticky
//   evt_count saturating count of cycles with any evt bit set
interface multi_edge_detector_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] clr;
  logic             cnt_clr;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] pedge;
  logic [WIDTH-1:0] nedge;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] sticky;
  logic             irq;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output in, mode, clr, cnt_clr,
    input  level, pedge, nedge, evt, sticky, irq, evt_count
  );

  modport slave (
    input  in, mode, clr, cnt_clr,
    output level, pedge, nedge, evt, sticky, irq, evt_count
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser and glitch filter, registered
// rising/falling edge pulses, mode-qualified events, write-1-to-clear sticky flags, an
// interrupt and a saturating event counter.
//   clk : sole clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : multi_edge_detector_if slave modport (see interface for signal list)
module multi_edge_detector #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst,
  multi_edge_detector_if.slave bus
);

  // Filter counter only needs to reach FILTER_LEN-1; keep at least one bit.
  localparam int unsigned     CfW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CfW-1:0]  CfMax = CfW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [CfW-1:0]   fcnt_q [WIDTH];
  logic [CfW-1:0]   fcnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pedge_q, pedge_d;
  logic [WIDTH-1:0] nedge_q, nedge_d;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Glitch filter: a differing level must persist FILTER_LEN sampled cycles; any
  // return to the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      fcnt_d[i] = '0;
      if (sync_s[i] != level_q[i]) begin
        if (fcnt_q[i] == CfMax) begin
          level_d[i] = sync_s[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + CfW'(1);
        end
      end
    end
  end

  // Edges registered alongside the level flip, so they are mutually exclusive.
  assign pedge_d = level_d & ~level_q;
  assign nedge_d = ~level_d & level_q;

  // Mode acts combinationally so a change is seen on the very next sample.
  assign evt = (pedge_q & {WIDTH{bus.mode[0]}}) | (nedge_q & {WIDTH{bus.mode[1]}});

  // Set wins over a concurrent clear.
  assign sticky_d = evt | (sticky_q & ~bus.clr);

  always_comb begin
    count_d = count_q;
    if (bus.cnt_clr) begin
      count_d = '0;
    end else if ((|evt) && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        fcnt_q[i] <= '0;
      end
      level_q  <= '0;
      pedge_q  <= '0;
      nedge_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      sync_q[0] <= bus.in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
      level_q  <= level_d;
      pedge_q  <= pedge_d;
      nedge_q  <= nedge_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.pedge     = pedge_q;
  assign bus.nedge     = nedge_q;
  assign bus.evt       = evt;
  assign bus.sticky    = sticky_q;
  assign bus.irq       = |sticky_q;
  assign bus.evt_count = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (WIDTH=8, SYNC_STAGES=2, FILTER_LEN=2, CNT_W=4).
module tb_multi_edge_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  multi_edge_detector_if #(.WIDTH(8), .CNT_W(4)) bus_if ();

  multi_edge_detector #(
    .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(2), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Advance past one rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_sticky();
    bus_if.clr = 8'hFF;
    step();
    bus_if.clr = 8'h00;
  endtask

  task automatic test_reset();
    bus_if.in = 8'h00; bus_if.mode = 2'b01; bus_if.clr = 8'h00; bus_if.cnt_clr = 1'b0;
    rst = 1'b1;
    step(2);
    total_cnt++; if (bus_if.level !== 8'h00) $display("FAIL rst_level got %h want 00", bus_if.level); else pass_cnt++;
    total_cnt++; if (bus_if.pedge !== 8'h00 || bus_if.nedge !== 8'h00) $display("FAIL rst_edges got %h/%h want 00/00", bus_if.pedge, bus_if.nedge); else pass_cnt++;
    total_cnt++; if (bus_if.sticky !== 8'h00 || bus_if.irq !== 1'b0) $display("FAIL rst_sticky got %h/%b want 00/0", bus_if.sticky, bus_if.irq); else pass_cnt++;
    total_cnt++; if (bus_if.evt_count !== 4'h0 || bus_if.evt !== 8'h00) $display("FAIL rst_count got %h/%h want 0/00", bus_if.evt_count, bus_if.evt); else pass_cnt++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_rising();
    bus_if.mode = 2'b01;
    bus_if.in = 8'h0C;
    step(3);
    total_cnt++; if (bus_if.pedge !== 8'h00) $display("FAIL rise_early got %h want 00", bus_if.pedge); else pass_cnt++;
    step();
    total_cnt++; if (bus_if.pedge !== 8'h0C || bus_if.nedge !== 8'h00) $display("FAIL rise_pedge got %h/%h want 0C/00", bus_if.pedge, bus_if.nedge); else pass_cnt++;
    total_cnt++; if (bus_if.level !== 8'h0C || bus_if.evt !== 8'h0C) $display("FAIL rise_level_evt got %h/%h want 0C/0C", bus_if.level, bus_if.evt); else pass_cnt++;
    step();
    total_cnt++; if (bus_if.pedge !== 8'h00) $display("FAIL rise_one_cycle got %h want 00", bus_if.pedge); else pass_cnt++;
    total_cnt++; if (bus_if.sticky !== 8'h0C || bus_if.irq !== 1'b1) $display("FAIL rise_sticky got %h/%b want 0C/1", bus_if.sticky, bus_if.irq); else pass_cnt++;
    total_cnt++; if (bus_if.evt_count !== 4'h1) $display("FAIL rise_count got %h want 1", bus_if.evt_count); else pass_cnt++;
    // Falling edge is not an event in rising-only mode.
    bus_if.in = 8'h00;
    step(4);
    total_cnt++; if (bus_if.nedge !== 8'h0C || bus_if.evt !== 8'h00) $display("FAIL fall_mode01 got %h/%h want 0C/00", bus_if.nedge, bus_if.evt); else pass_cnt++;
    step();
    total_cnt++; if (bus_if.evt_count !== 4'h1) $display("FAIL fall_mode01_count got %h want 1", bus_if.evt_count); else pass_cnt++;
    clear_sticky();
    total_cnt++; if (bus_if.sticky !== 8'h00 || bus_if.irq !== 1'b0) $display("FAIL clr_all got %h/%b want 00/0", bus_if.sticky, bus_if.irq); else pass_cnt++;
  endtask

  task automatic test_both_edges();
    bus_if.mode = 2'b11;
    bus_if.cnt_clr = 1'b1;
    step();
    bus_if.cnt_clr = 1'b0;
    total_cnt++; if (bus_if.evt_count !== 4'h0) $display("FAIL cnt_clr got %h want 0", bus_if.evt_count); else pass_cnt++;
    bus_if.in = 8'h4E;
    step(4);
    total_cnt++; if (bus_if.pedge !== 8'h4E || bus_if.evt !== 8'h4E) $display("FAIL both_rise got %h/%h want 4E/4E", bus_if.pedge, bus_if.evt); else pass_cnt++;
    step();
    total_cnt++; if (bus_if.pedge !== 8'h00) $display("FAIL both_rise_once got %h want 00", bus_if.pedge); else pass_cnt++;
    bus_if.in = 8'h00;
    step(4);
    total_cnt++; if (bus_if.nedge !== 8'h4E || bus_if.evt !== 8'h4E || bus_if.pedge !== 8'h00) $display("FAIL both_fall got %h/%h/%h want 4E/4E/00", bus_if.nedge, bus_if.evt, bus_if.pedge); else pass_cnt++;
    // Mode is applied combinationally.
    bus_if.mode = 2'b00;
    #1;
    total_cnt++; if (bus_if.evt !== 8'h00 || bus_if.nedge !== 8'h4E) $display("FAIL mode_none got %h/%h want 00/4E", bus_if.evt, bus_if.nedge); else pass_cnt++;
    bus_if.mode = 2'b11;
    #1;
    step();
    total_cnt++; if (bus_if.evt_count !== 4'h2 || bus_if.sticky !== 8'h4E) $display("FAIL both_count got %h/%h want 2/4E", bus_if.evt_count, bus_if.sticky); else pass_cnt++;
    clear_sticky();
  endtask

  task automatic test_glitch();
    int seen = 0;
    int p_at = -1;
    int n_at = -1;
    int p_num = 0;
    bus_if.mode = 2'b11;
    bus_if.in = 8'h01;
    step();
    bus_if.in = 8'h00;
    for (int s = 0; s < 6; s++) begin
      step();
      if (bus_if.pedge[0] || bus_if.level[0]) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL glitch_1cyc got %0d hits want 0", seen); else pass_cnt++;
    bus_if.in = 8'h01;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (s == 2) bus_if.in = 8'h00;
      if (bus_if.pedge[0]) begin
        p_num++;
        if (p_at < 0) p_at = s;
      end
      if (bus_if.nedge[0] && n_at < 0) n_at = s;
    end
    total_cnt++; if (p_at !== 4 || p_num !== 1) $display("FAIL glitch_2cyc_pedge got at %0d x%0d want at 4 x1", p_at, p_num); else pass_cnt++;
    total_cnt++; if (n_at !== 6) $display("FAIL glitch_2cyc_nedge got at %0d want at 6", n_at); else pass_cnt++;
    clear_sticky();
  endtask

  task automatic test_sticky_clr();
    bus_if.mode = 2'b01;
    bus_if.in = 8'h45;
    step(6);
    total_cnt++; if (bus_if.sticky !== 8'h45) $display("FAIL sticky_set got %h want 45", bus_if.sticky); else pass_cnt++;
    bus_if.clr = 8'h01;
    step();
    bus_if.clr = 8'h00;
    total_cnt++; if (bus_if.sticky !== 8'h44) $display("FAIL sticky_clr01 got %h want 44", bus_if.sticky); else pass_cnt++;
    bus_if.in = 8'h41;
    step(6);
    bus_if.in = 8'h45;
    step(4);
    total_cnt++; if (bus_if.evt !== 8'h04) $display("FAIL sticky_new_evt got %h want 04", bus_if.evt); else pass_cnt++;
    bus_if.clr = 8'h04;
    step();
    bus_if.clr = 8'h00;
    total_cnt++; if (bus_if.sticky !== 8'h44) $display("FAIL sticky_set_wins got %h want 44", bus_if.sticky); else pass_cnt++;
    bus_if.clr = 8'h04;
    step();
    bus_if.clr = 8'h00;
    total_cnt++; if (bus_if.sticky !== 8'h40) $display("FAIL sticky_clr04 got %h want 40", bus_if.sticky); else pass_cnt++;
    clear_sticky();
    total_cnt++; if (bus_if.irq !== 1'b0) $display("FAIL sticky_irq_off got %b want 0", bus_if.irq); else pass_cnt++;
  endtask

  task automatic test_counter();
    bus_if.mode = 2'b11;
    bus_if.cnt_clr = 1'b1;
    step();
    bus_if.cnt_clr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      bus_if.in = bus_if.in ^ 8'h80;
      step(6);
      if (n == 10) begin
        total_cnt++; if (bus_if.evt_count !== 4'hA) $display("FAIL cnt_ten got %h want A", bus_if.evt_count); else pass_cnt++;
      end
    end
    total_cnt++; if (bus_if.evt_count !== 4'hF) $display("FAIL cnt_saturate got %h want F", bus_if.evt_count); else pass_cnt++;
    bus_if.in = bus_if.in ^ 8'h80;
    step(4);
    total_cnt++; if (bus_if.evt !== 8'h80) $display("FAIL cnt_clr_evt got %h want 80", bus_if.evt); else pass_cnt++;
    bus_if.cnt_clr = 1'b1;
    step();
    bus_if.cnt_clr = 1'b0;
    total_cnt++; if (bus_if.evt_count !== 4'h0) $display("FAIL cnt_clr_wins got %h want 0", bus_if.evt_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int p_at = -1;
    total_cnt++; if (bus_if.irq !== 1'b1 || bus_if.level === 8'h00) $display("FAIL pre_rst_state got %b/%h want 1/nonzero", bus_if.irq, bus_if.level); else pass_cnt++;
    bus_if.in = 8'h00;
    step(3);
    rst = 1'b1;
    #1;
    total_cnt++; if (bus_if.level !== 8'h00 || bus_if.sticky !== 8'h00 || bus_if.irq !== 1'b0) $display("FAIL async_rst got %h/%h/%b want 00/00/0", bus_if.level, bus_if.sticky, bus_if.irq); else pass_cnt++;
    bus_if.in = 8'h45;
    step(2);
    rst = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      if (bus_if.pedge !== 8'h00 && p_at < 0) begin
        p_at = s;
        total_cnt++; if (bus_if.pedge !== 8'h45) $display("FAIL post_rst_pedge got %h want 45", bus_if.pedge); else pass_cnt++;
      end
    end
    total_cnt++; if (p_at !== 4) $display("FAIL post_rst_latency got %0d want 4", p_at); else pass_cnt++;
  endtask

  initial begin
    bus_if.in = 8'h00; bus_if.mode = 2'b01; bus_if.clr = 8'h00; bus_if.cnt_clr = 1'b0;
    test_reset();
    test_rising();
    test_both_edges();
    test_glitch();
    test_sticky_clr();
    test_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector for asynchronous or noisy level inputs. Each channel passes through a synchroniser and a glitch filter. Rising and falling edges are then detected on the filtered level, and qualified events are latched into write-1-to-clear sticky flags that drive an interrupt and a saturating event counter. It replaces the fixed 8-bit rising-edge-only detector wherever inputs come from pins, other clock domains, or bouncing sources.

## Interface
- WIDTH, 8, number of independent channels
- SYNC_STAGES, 2, synchroniser flops per channel (legal ≥ 2)
- FILTER_LEN, 2, consecutive cycles a new level must persist before acceptance (legal ≥ 1)
- CNT_W, 8, event counter width
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in  in  WIDTH  raw level inputs, may be asynchronous to clk
- mode  in  2  event qualifier, all channels: 00 none, 01 rising, 10 falling, 11 both
- clr  in  WIDTH  per-channel write-1-to-clear for sticky
- cnt_clr  in  1  synchronous clear of evt_count
- level  out  WIDTH  filtered level per channel
- pedge  out  WIDTH  one-cycle pulse on accepted 0→1 of level
- nedge  out  WIDTH  one-cycle pulse on accepted 1→0 of level
- evt  out  WIDTH  pedge/nedge qualified by mode
- sticky  out  WIDTH  latched evt per channel
- irq  out  1  OR of sticky
- evt_count  out  CNT_W  cycles with any evt bit set, saturating

## Operation
- Synchroniser: in[i] → SYNC_STAGES flop chain → s[i].
- Filter, per channel: level register f[i] and counter c[i] in 0..FILTER_LEN-1.
  - s == f: c ← 0.
  - s != f and c < FILTER_LEN-1: c ← c+1.
  - s != f and c == FILTER_LEN-1: f ← s, c ← 0.
  - A difference that vanishes before acceptance resets c; the pulse is discarded.
- Edge outputs are registered and assert for exactly the one cycle after the edge on which f flips.
  - pedge[i] on 0→1; nedge[i] on 1→0.
  - pedge[i] and nedge[i] are never high together.
- evt[i] = (pedge[i] & mode[0]) | (nedge[i] & mode[1]). It is combinational from the registered edges and the current mode.
- sticky[i] is set on any cycle with evt[i]=1 and cleared on a cycle with clr[i]=1 and evt[i]=0. Set wins when both occur in the same cycle.
- irq = |sticky.
- evt_count:
  - Increments by 1 on each edge where |evt = 1, regardless of how many bits are set.
  - Holds at 2^CNT_W-1.
  - If cnt_clr and |evt occur in the same cycle, the result is 0 (clear wins).
- mode changes act immediately on evt. They never affect the filter, level, pedge, or nedge.
- Reset state: all flops 0, so level, pedge, nedge, evt, sticky, irq, and evt_count are all 0. An input held at 1 through reset yields one pedge after release.

## Timing
- Latency: in changes before edge k. s reflects the change after edge k+SYNC_STAGES-1. f and pedge/nedge update at edge k+SYNC_STAGES+FILTER_LEN-1. The pulse is visible for one cycle after that edge.
- Defaults (SYNC_STAGES=2, FILTER_LEN=2): pedge high after edge k+3. sticky high after edge k+4, as does evt_count+1.
- Minimum accepted pulse width is FILTER_LEN cycles after synchronisation. Pulses of FILTER_LEN-1 or fewer cycles are always rejected.
- Channels are fully independent. Simultaneous events on several channels all set sticky but add only 1 to evt_count.
- Asynchronous rst mid-operation clears every flop immediately, including in-flight filter counts. The first accepted edge after release follows the full latency.

## Test plan
- Defaults, mode=01: in 00→0C held 5 cycles → pedge=0C for exactly one cycle, 4 cycles after change; sticky=0C; irq=1; evt_count=1.
- mode=11: in 00→4E held, then 4E→00 held → pedge=4E once, then nedge=4E once; evt_count=2; with mode=01 the falling edge gives evt=0 and the count stays 1.
- Glitch: in bit0 high for 1 cycle with FILTER_LEN=2 → no pedge, level[0] stays 0; 2-cycle pulse → pedge[0] and later nedge[0].
- Sticky clear: sticky=45, clr=01 → sticky=44; clr=04 on the same cycle as a new evt[2] → sticky[2] stays 1; clr=FF → irq=0.
- Counter: CNT_W=4, 20 separated events → evt_count saturates at F; cnt_clr concurrent with an event → 0.
- Reset: assert rst mid-filter (c=1) → all outputs 0 asynchronously; in held at 45 through release → pedge=45 at SYNC_STAGES+FILTER_LEN edges after release.
